// File: rtl/fifo_load_sched.sv
// Load/compute pass sequencer around the FIFO row packer.
// Gates the FIFO, writes packed rows to the operand buffer, then runs compute.
module fifo_load_sched #(
  parameter int ROW_W  = 7,
  parameter int DATA_W = 64
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              go,
  input  logic [ROW_W-1:0]  num_rows,
  input  logic              mode_single,
  input  logic              row_valid,
  input  logic [DATA_W-1:0] row_data,
  input  logic              compute_done,
  output logic              enable,
  output logic              enable_single,
  output logic              wr_en,
  output logic [ROW_W-1:0]  wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              start,
  output logic              busy,
  output logic              done,
  output logic              err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FILL,
    S_FLUSH,
    S_START,
    S_WAIT,
    S_DONE
  } state_t;

  localparam logic [ROW_W-1:0] ONE = {{(ROW_W-1){1'b0}}, 1'b1};

  state_t           r_state;
  logic [ROW_W-1:0] r_cnt;
  logic [ROW_W-1:0] r_num;
  logic             w_last;

  assign w_last = (r_cnt == (r_num - ONE));

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state       <= S_IDLE;
      r_cnt         <= '0;
      r_num         <= '0;
      enable        <= 1'b0;
      enable_single <= 1'b0;
      wr_en         <= 1'b0;
      wr_addr       <= '0;
      wr_data       <= '0;
      start         <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      err           <= 1'b0;
    end else begin
      wr_en <= 1'b0;
      start <= 1'b0;
      done  <= 1'b0;
      // stray rows are flagged but never written
      if (row_valid && (r_state != S_FILL))
        err <= 1'b1;
      unique case (r_state)
        S_IDLE: begin
          if (go) begin
            if (num_rows != '0) begin
              r_num         <= num_rows;
              r_cnt         <= '0;
              err           <= 1'b0;
              enable        <= 1'b1;
              enable_single <= mode_single;
              busy          <= 1'b1;
              r_state       <= S_FILL;
            end else begin
              err <= 1'b1;
            end
          end
        end
        S_FILL: begin
          if (row_valid) begin
            wr_en   <= 1'b1;
            wr_addr <= r_cnt;
            wr_data <= row_data;
            r_cnt   <= r_cnt + ONE;
            if (w_last) begin
              enable        <= 1'b0;
              enable_single <= 1'b0;
              r_state       <= S_FLUSH;
            end
          end
        end
        S_FLUSH: begin
          start   <= 1'b1;
          r_state <= S_START;
        end
        S_START: begin
          r_state <= S_WAIT;
        end
        S_WAIT: begin
          if (compute_done) begin
            done    <= 1'b1;
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          busy    <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_load_sched.sv
// Scoreboard bench for fifo_load_sched: expected writes/start/done
// are queued by the stimulus and popped by an output monitor.
module tb_fifo_load_sched;

  localparam int ROW_W  = 7;
  localparam int DATA_W = 64;

  localparam logic [1:0] K_WR = 2'd0;
  localparam logic [1:0] K_ST = 2'd1;
  localparam logic [1:0] K_DN = 2'd2;

  typedef struct {
    logic [1:0]        kind;
    logic [ROW_W-1:0]  addr;
    logic [DATA_W-1:0] data;
  } ev_t;

  logic              clk = 1'b0;
  logic              resetn;
  logic              go;
  logic [ROW_W-1:0]  num_rows;
  logic              mode_single;
  logic              row_valid;
  logic [DATA_W-1:0] row_data;
  logic              compute_done;
  logic              enable;
  logic              enable_single;
  logic              wr_en;
  logic [ROW_W-1:0]  wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              start;
  logic              busy;
  logic              done;
  logic              err;

  int n_pass = 0;
  int n_tot  = 0;
  ev_t exp_q[$];

  fifo_load_sched #(.ROW_W(ROW_W), .DATA_W(DATA_W)) dut (
    .clk(clk),
    .resetn(resetn),
    .go(go),
    .num_rows(num_rows),
    .mode_single(mode_single),
    .row_valid(row_valid),
    .row_data(row_data),
    .compute_done(compute_done),
    .enable(enable),
    .enable_single(enable_single),
    .wr_en(wr_en),
    .wr_addr(wr_addr),
    .wr_data(wr_data),
    .start(start),
    .busy(busy),
    .done(done),
    .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [127:0] act,
                     input logic [127:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic push(input logic [1:0] k, input logic [ROW_W-1:0] a,
                      input logic [DATA_W-1:0] d);
    ev_t e;
    e.kind = k;
    e.addr = a;
    e.data = d;
    exp_q.push_back(e);
  endtask

  task automatic pop_chk(input logic [1:0] k, input string nm);
    ev_t e;
    if (exp_q.size() == 0) begin
      n_tot++;
      $display("FAIL unexpected_%s: got pulse expected none", nm);
    end else begin
      e = exp_q.pop_front();
      chk({nm, "_kind"}, 128'(k), 128'(e.kind));
      if (k == K_WR && e.kind == K_WR) begin
        chk("wr_addr", 128'(wr_addr), 128'(e.addr));
        chk("wr_data", 128'(wr_data), 128'(e.data));
      end
    end
  endtask

  always @(negedge clk) begin
    if (resetn === 1'b1) begin
      if (wr_en) pop_chk(K_WR, "wr");
      if (start) pop_chk(K_ST, "start");
      if (done)  pop_chk(K_DN, "done");
    end
  end

  task automatic issue_go(input logic [ROW_W-1:0] n, input logic m);
    go = 1'b1;
    num_rows = n;
    mode_single = m;
    @(negedge clk);
    go = 1'b0;
  endtask

  task automatic row(input logic [ROW_W-1:0] a, input logic [DATA_W-1:0] d,
                     input bit last);
    push(K_WR, a, d);
    if (last) push(K_ST, '0, '0);
    row_valid = 1'b1;
    row_data = d;
    @(negedge clk);
    row_valid = 1'b0;
  endtask

  // called in WAIT; completes the pass after 'gap' idle cycles
  task automatic complete(input int gap);
    repeat (gap) @(negedge clk);
    push(K_DN, '0, '0);
    compute_done = 1'b1;
    @(negedge clk);
    compute_done = 1'b0;
    chk("done_hi", 128'(done), 128'(1));
    chk("busy_in_done", 128'(busy), 128'(1));
    @(negedge clk);
    chk("done_lo", 128'(done), 128'(0));
    chk("busy_end", 128'(busy), 128'(0));
  endtask

  initial begin
    resetn = 1'b0;
    go = 1'b0;
    num_rows = '0;
    mode_single = 1'b0;
    row_valid = 1'b0;
    row_data = '0;
    compute_done = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_outs", 128'({enable, enable_single, wr_en, wr_addr, wr_data,
                            start, busy, done, err}), 128'(0));
    resetn = 1'b1;
    @(negedge clk);
    chk("idle_outs", 128'({enable, wr_en, start, busy, done, err}), 128'(0));

    // zero-row command is rejected
    issue_go(7'd0, 1'b0);
    chk("zero_err", 128'(err), 128'(1));
    chk("zero_busy", 128'(busy), 128'(0));
    chk("zero_en", 128'(enable), 128'(0));

    // 4 rows, gapped
    issue_go(7'd4, 1'b0);
    chk("p4_busy", 128'(busy), 128'(1));
    chk("p4_en", 128'(enable), 128'(1));
    chk("p4_errclr", 128'(err), 128'(0));
    chk("p4_ensgl", 128'(enable_single), 128'(0));
    row(7'd0, 64'h1111_1111_1111_1111, 1'b0);
    @(negedge clk);
    row(7'd1, 64'h2222_2222_2222_2222, 1'b0);
    @(negedge clk);
    @(negedge clk);
    row(7'd2, 64'h3333_3333_3333_3333, 1'b0);
    @(negedge clk);
    row(7'd3, 64'h4444_4444_4444_4444, 1'b1);
    chk("p4_en_off", 128'(enable), 128'(0));
    chk("p4_flush_wr", 128'(wr_en), 128'(1));
    chk("p4_no_start_yet", 128'(start), 128'(0));
    @(negedge clk);
    chk("p4_start", 128'(start), 128'(1));
    chk("p4_start_nowr", 128'(wr_en), 128'(0));
    @(negedge clk);
    chk("p4_start_1cyc", 128'(start), 128'(0));
    complete(4);

    // maximum count, back-to-back rows
    issue_go(7'd127, 1'b0);
    for (int i = 0; i < 127; i++)
      row(7'(i), 64'hA5A5_A5A5_0000_0000 | 64'(i), i == 126);
    chk("p127_en_off", 128'(enable), 128'(0));
    @(negedge clk);
    chk("p127_start", 128'(start), 128'(1));
    @(negedge clk);
    complete(2);

    // single mode plus stray row in WAIT
    issue_go(7'd2, 1'b1);
    chk("sg_ensgl", 128'(enable_single), 128'(1));
    row(7'd0, 64'hDEAD_BEEF_0000_0001, 1'b0);
    chk("sg_ensgl_fill", 128'(enable_single), 128'(1));
    row(7'd1, 64'hDEAD_BEEF_0000_0002, 1'b1);
    chk("sg_ensgl_off", 128'(enable_single), 128'(0));
    @(negedge clk);
    @(negedge clk);
    row_valid = 1'b1;
    row_data = 64'hBAD0_BAD0_BAD0_BAD0;
    @(negedge clk);
    row_valid = 1'b0;
    chk("stray_err", 128'(err), 128'(1));
    complete(1);
    chk("err_sticky", 128'(err), 128'(1));

    // go in WAIT ignored, early compute_done ignored
    issue_go(7'd3, 1'b0);
    chk("p3_errclr", 128'(err), 128'(0));
    row(7'd0, 64'h0123_4567_89AB_CDEF, 1'b0);
    row(7'd1, 64'hFEDC_BA98_7654_3210, 1'b0);
    row(7'd2, 64'h5555_AAAA_5555_AAAA, 1'b1);
    @(negedge clk);
    chk("p3_start", 128'(start), 128'(1));
    compute_done = 1'b1;
    @(negedge clk);
    compute_done = 1'b0;
    chk("early_cd_done", 128'(done), 128'(0));
    issue_go(7'd9, 1'b1);
    repeat (2) @(negedge clk);
    chk("wait_busy", 128'(busy), 128'(1));
    chk("wait_en", 128'(enable), 128'(0));
    chk("busy_go_noerr", 128'(err), 128'(0));
    complete(0);
    repeat (2) @(negedge clk);
    chk("after_idle", 128'({enable, busy, err}), 128'(0));

    // reset mid-pass
    issue_go(7'd8, 1'b0);
    row(7'd0, 64'h7777_0000_0000_0000, 1'b0);
    row(7'd1, 64'h7777_0000_0000_0001, 1'b0);
    #2 resetn = 1'b0;
    #1;
    chk("rst_async", 128'({enable, wr_en, busy}), 128'(0));
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    issue_go(7'd3, 1'b0);
    row(7'd0, 64'h9999_0000_0000_0000, 1'b0);
    row(7'd1, 64'h9999_0000_0000_0001, 1'b0);
    row(7'd2, 64'h9999_0000_0000_0002, 1'b1);
    @(negedge clk);
    @(negedge clk);
    complete(1);

    repeat (3) @(negedge clk);
    chk("queue_empty", 128'(exp_q.size()), 128'(0));
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
